// File: rtl/downconverter_fs4_decim_pkg.sv
`default_nettype none
// ============================================================================
// Module : downconverter_pkg
// Brief  : Mode encoding, fs/4 LO sign lookup and saturating negation shared
//          by the fs/4 downconverter/decimator.
// Rev    : 1.0  initial release
// ============================================================================
package downconverter_pkg;

    typedef enum logic {
        MODE_MIX_FS4 = 1'b0,
        MODE_BYPASS  = 1'b1
    } mode_e;

    // Bit p set: that rail takes +x (POS) or -x (NEG) at LO phase p.
    localparam logic [3:0] c_I_POS = 4'b0001;
    localparam logic [3:0] c_I_NEG = 4'b0100;
    localparam logic [3:0] c_Q_POS = 4'b1000;
    localparam logic [3:0] c_Q_NEG = 4'b0010;

    localparam int c_MAX_W = 64;

    // Negate a sign-extended value of the given width; the most negative
    // code maps to the most positive one instead of wrapping.
    function automatic logic signed [c_MAX_W-1:0] sat_neg(
        input logic signed [c_MAX_W-1:0] x,
        input int                        width
    );
        logic signed [c_MAX_W-1:0] min_v;
        min_v = {c_MAX_W{1'b1}} << (width - 1);
        return (x == min_v) ? ~min_v : -x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/downconverter_fs4_decim_integrate_dump.sv
`default_nettype none
// ============================================================================
// Module : integrate_dump
// Brief  : Integrate-and-dump averager for one rail; output is the frame sum
//          arithmetically shifted down by log2(DECIM).
// Rev    : 1.0  initial release
// ============================================================================
module integrate_dump #(
    parameter  int WIDTH      = 16,
    parameter  int DECIM      = 4,
    localparam int LOG2_DECIM = $clog2(DECIM)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_valid,
    input  logic                    i_dump,
    input  logic signed [WIDTH-1:0] i_sample,
    output logic signed [WIDTH-1:0] o_data
);

    localparam int c_ACC_W = WIDTH + LOG2_DECIM;

    logic signed [c_ACC_W-1:0] r_acc;
    logic signed [c_ACC_W-1:0] w_sum;
    logic signed [WIDTH-1:0]   w_avg;
    logic signed [WIDTH-1:0]   r_data;

    assign w_sum  = r_acc + c_ACC_W'(i_sample);
    // Upper WIDTH bits of the sum are the arithmetic right shift (floor).
    assign w_avg  = w_sum[c_ACC_W-1:LOG2_DECIM];
    assign o_data = r_data;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_acc  <= '0;
            r_data <= '0;
        end else if (i_valid) begin
            if (i_dump) begin
                r_acc  <= '0;
                r_data <= w_avg;
            end else begin
                r_acc  <= w_sum;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/downconverter_fs4_decim.sv
`default_nettype none
// ============================================================================
// Module : downconverter_fs4_decim
// Brief  : Real-to-complex fs/4 mixer (or bypass) followed by a DECIM-fold
//          integrate-and-dump decimator on each rail.
// Rev    : 1.0  initial release
// ============================================================================
module downconverter_fs4_decim
    import downconverter_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int DECIM      = 4,
    localparam int LOG2_DECIM = $clog2(DECIM)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_mode,
    input  logic signed [WIDTH-1:0] i_in_data,
    input  logic                    i_in_valid,
    output logic signed [WIDTH-1:0] o_out_i,
    output logic signed [WIDTH-1:0] o_out_q,
    output logic                    o_out_valid
);

    localparam int                 c_CNT_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DECIM - 1);

    logic [1:0]              r_phase;
    logic [c_CNT_W-1:0]      r_decim_cnt;
    mode_e                   r_mode;
    logic                    r_out_valid;
    mode_e                   w_mode;
    logic                    w_dump;
    logic signed [WIDTH-1:0] w_neg;
    logic signed [WIDTH-1:0] w_mix_i;
    logic signed [WIDTH-1:0] w_mix_q;

    // The first sample of a frame uses the live mode; the rest use the latch.
    assign w_mode = (r_decim_cnt == '0) ? mode_e'(i_mode) : r_mode;
    assign w_dump = i_in_valid && (r_decim_cnt == c_LAST);
    assign w_neg  = WIDTH'(sat_neg(c_MAX_W'(i_in_data), WIDTH));

    always_comb begin
        w_mix_i = '0;
        w_mix_q = '0;
        if (w_mode == MODE_BYPASS) begin
            w_mix_i = i_in_data;
        end else begin
            if (c_I_POS[r_phase])      w_mix_i = i_in_data;
            else if (c_I_NEG[r_phase]) w_mix_i = w_neg;
            if (c_Q_POS[r_phase])      w_mix_q = i_in_data;
            else if (c_Q_NEG[r_phase]) w_mix_q = w_neg;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_phase     <= '0;
            r_decim_cnt <= '0;
            r_mode      <= MODE_MIX_FS4;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_dump;
            if (i_in_valid) begin
                r_phase     <= r_phase + 2'd1;
                r_decim_cnt <= w_dump ? '0 : r_decim_cnt + 1'b1;
                if (r_decim_cnt == '0) r_mode <= mode_e'(i_mode);
            end
        end
    end

    integrate_dump #(
        .WIDTH (WIDTH),
        .DECIM (DECIM)
    ) u_integ_i (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_valid  (i_in_valid),
        .i_dump   (w_dump),
        .i_sample (w_mix_i),
        .o_data   (o_out_i)
    );

    integrate_dump #(
        .WIDTH (WIDTH),
        .DECIM (DECIM)
    ) u_integ_q (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_valid  (i_in_valid),
        .i_dump   (w_dump),
        .i_sample (w_mix_q),
        .o_data   (o_out_q)
    );

    assign o_out_valid = r_out_valid;

endmodule
`default_nettype wire
